// File: rtl/imm_encode.sv
// RV32I immediate encoder: packs an immediate into I/S/B/J/U instruction fields of a
// template word, flags unrepresentable immediates, and delivers through a 2-stage pipeline.
module imm_encode #(
    parameter int unsigned ERR_CNT_W = 8
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [2:0]           immsrc,
    input  logic [31:0]          imm,
    input  logic [31:0]          base,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [31:0]          out_instr,
    output logic [1:0]           out_err,
    output logic [ERR_CNT_W-1:0] err_cnt,
    input  logic                 err_clr
);

    logic                 s1_valid_q, s1_valid_d;
    logic [31:0]          s1_instr_q, s1_instr_d;
    logic [1:0]           s1_err_q,   s1_err_d;
    logic                 s2_valid_q, s2_valid_d;
    logic [31:0]          s2_instr_q, s2_instr_d;
    logic [1:0]           s2_err_q,   s2_err_d;
    logic [ERR_CNT_W-1:0] err_cnt_q,  err_cnt_d;

    logic [31:0] pack_instr;
    logic [1:0]  pack_err;
    logic        rng11_ok, rng12_ok, rng20_ok;
    logic        s1_adv, accept, err_hs;

    always_comb begin
        rng11_ok   = (imm[31:11] == '0) || (imm[31:11] == '1);
        rng12_ok   = (imm[31:12] == '0) || (imm[31:12] == '1);
        rng20_ok   = (imm[31:20] == '0) || (imm[31:20] == '1);
        pack_instr = base;
        pack_err   = 2'b00;
        // Alignment/low-bit faults are assigned after range faults so they win.
        case (immsrc)
            3'b000: begin
                pack_instr[31:20] = imm[11:0];
                if (!rng11_ok) pack_err = 2'b01;
            end
            3'b001: begin
                pack_instr[31:25] = imm[11:5];
                pack_instr[11:7]  = imm[4:0];
                if (!rng11_ok) pack_err = 2'b01;
            end
            3'b010: begin
                pack_instr[31]    = imm[12];
                pack_instr[30:25] = imm[10:5];
                pack_instr[11:8]  = imm[4:1];
                pack_instr[7]     = imm[11];
                if (!rng12_ok) pack_err = 2'b01;
                if (imm[0])    pack_err = 2'b10;
            end
            3'b011: begin
                pack_instr[31]    = imm[20];
                pack_instr[30:21] = imm[10:1];
                pack_instr[20]    = imm[11];
                pack_instr[19:12] = imm[19:12];
                if (!rng20_ok) pack_err = 2'b01;
                if (imm[0])    pack_err = 2'b10;
            end
            3'b100: begin
                pack_instr[31:12] = imm[31:12];
                if (imm[11:0] != '0) pack_err = 2'b10;
            end
            default: pack_err = 2'b11;
        endcase
    end

    always_comb begin
        s1_adv   = s1_valid_q && (!s2_valid_q || out_ready);
        in_ready = !s1_valid_q || s1_adv;
        accept   = in_valid && in_ready;

        s1_valid_d = s1_valid_q;
        s1_instr_d = s1_instr_q;
        s1_err_d   = s1_err_q;
        if (accept) begin
            s1_valid_d = 1'b1;
            s1_instr_d = pack_instr;
            s1_err_d   = pack_err;
        end else if (s1_adv) begin
            s1_valid_d = 1'b0;
        end

        s2_valid_d = s2_valid_q;
        s2_instr_d = s2_instr_q;
        s2_err_d   = s2_err_q;
        if (s1_adv) begin
            s2_valid_d = 1'b1;
            s2_instr_d = s1_instr_q;
            s2_err_d   = s1_err_q;
        end else if (s2_valid_q && out_ready) begin
            s2_valid_d = 1'b0;
        end
    end

    always_comb begin
        err_hs    = s2_valid_q && out_ready && (s2_err_q != 2'b00);
        err_cnt_d = err_cnt_q;
        // Clear wins, but an errored handshake in the same cycle is still counted.
        if (err_clr) begin
            err_cnt_d = err_hs ? ERR_CNT_W'(1) : '0;
        end else if (err_hs && (err_cnt_q != '1)) begin
            err_cnt_d = err_cnt_q + ERR_CNT_W'(1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1_valid_q <= 1'b0;
            s1_instr_q <= '0;
            s1_err_q   <= '0;
            s2_valid_q <= 1'b0;
            s2_instr_q <= '0;
            s2_err_q   <= '0;
            err_cnt_q  <= '0;
        end else begin
            s1_valid_q <= s1_valid_d;
            s1_instr_q <= s1_instr_d;
            s1_err_q   <= s1_err_d;
            s2_valid_q <= s2_valid_d;
            s2_instr_q <= s2_instr_d;
            s2_err_q   <= s2_err_d;
            err_cnt_q  <= err_cnt_d;
        end
    end

    assign out_valid = s2_valid_q;
    assign out_instr = s2_instr_q;
    assign out_err   = s2_err_q;
    assign err_cnt   = err_cnt_q;

endmodule

// File: tb/tb_imm_encode.sv
// Scoreboard bench for imm_encode: arithmetic reference packer plus an independent
// immediate extender used to confirm round-trip on error-free results.
module tb_imm_encode;

    localparam int unsigned CW = 8;
    localparam int          CNT_MAX = (1 << CW) - 1;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          in_valid = 1'b0;
    logic          in_ready;
    logic [2:0]    immsrc = '0;
    logic [31:0]   imm = '0;
    logic [31:0]   base = '0;
    logic          out_valid;
    logic          out_ready = 1'b0;
    logic [31:0]   out_instr;
    logic [1:0]    out_err;
    logic [CW-1:0] err_cnt;
    logic          err_clr = 1'b0;

    imm_encode #(.ERR_CNT_W(CW)) dut (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
        .immsrc(immsrc), .imm(imm), .base(base), .out_valid(out_valid),
        .out_ready(out_ready), .out_instr(out_instr), .out_err(out_err),
        .err_cnt(err_cnt), .err_clr(err_clr)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [2:0]  src;
        logic [31:0] imm;
        logic [31:0] instr;
        logic [1:0]  err;
    } exp_t;

    exp_t sb[$];
    int   checks = 0;
    int   errors = 0;
    int   rdy_mode = 0;   // 0 hold low, 1 high, 2 random
    int   exp_cnt = 0;

    function automatic void check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endfunction

    function automatic void ref_pack(input logic [2:0] src, input logic [31:0] im, input logic [31:0] bs,
                                     output logic [31:0] ins, output logic [1:0] er);
        int signed s;
        s   = $signed(im);
        ins = bs;
        er  = 2'b00;
        case (src)
            3'd0: begin
                ins = (bs & 32'h000F_FFFF) | (im << 20);
                if (s < -2048 || s > 2047) er = 2'b01;
            end
            3'd1: begin
                ins = (bs & 32'h01FF_F07F) | (((im >> 5) & 32'h7F) << 25) | ((im & 32'h1F) << 7);
                if (s < -2048 || s > 2047) er = 2'b01;
            end
            3'd2: begin
                ins = (bs & 32'h01FF_F07F) | (((im >> 12) & 32'h1) << 31) | (((im >> 5) & 32'h3F) << 25)
                    | (((im >> 1) & 32'hF) << 8) | (((im >> 11) & 32'h1) << 7);
                if (s < -4096 || s > 4095) er = 2'b01;
                if ((im & 32'h1) != 0) er = 2'b10;
            end
            3'd3: begin
                ins = (bs & 32'h0000_0FFF) | (((im >> 20) & 32'h1) << 31) | (((im >> 1) & 32'h3FF) << 21)
                    | (((im >> 11) & 32'h1) << 20) | (im & 32'h000F_F000);
                if (s < -1048576 || s > 1048575) er = 2'b01;
                if ((im & 32'h1) != 0) er = 2'b10;
            end
            3'd4: begin
                ins = (bs & 32'h0000_0FFF) | (im & 32'hFFFF_F000);
                if ((im & 32'hFFF) != 0) er = 2'b10;
            end
            default: er = 2'b11;
        endcase
    endfunction

    function automatic logic [31:0] extend(input logic [2:0] src, input logic [31:0] i);
        case (src)
            3'd0:    return {{20{i[31]}}, i[31:20]};
            3'd1:    return {{20{i[31]}}, i[31:25], i[11:7]};
            3'd2:    return {{19{i[31]}}, i[31], i[7], i[30:25], i[11:8], 1'b0};
            3'd3:    return {{11{i[31]}}, i[31], i[19:12], i[20], i[30:21], 1'b0};
            default: return {i[31:12], 12'h000};
        endcase
    endfunction

    function automatic logic [31:0] rand_imm();
        int b[12] = '{2047, 2048, -2048, -2049, 4094, 4096, -4096, -4098,
                      1048574, 1048576, -1048576, -1048578};
        logic [31:0] v;
        case ($urandom_range(0, 4))
            0:       v = $urandom;
            1:       v = $urandom_range(0, 8191) - 4096;
            2:       v = $urandom_range(0, (1 << 22) - 1) - (1 << 21);
            3:       v = $urandom & 32'hFFFF_F000;
            default: v = b[$urandom_range(0, 11)];
        endcase
        if ($urandom_range(0, 1) == 1) v[0] = 1'b0;
        return v;
    endfunction

    always begin
        @(posedge clk);
        #2;
        out_ready = (rdy_mode == 1) || (rdy_mode == 2 && $urandom_range(0, 2) != 0);
    end

    // Monitor: scoreboard pop, output-hold property and error-counter model.
    initial begin
        exp_t        e;
        logic        prev_stall = 1'b0;
        logic [31:0] prev_instr = '0;
        logic [1:0]  prev_err = '0;
        logic        herr;
        forever begin
            @(negedge clk);
            if (!rst_n) begin
                exp_cnt    = 0;
                prev_stall = 1'b0;
            end else begin
                check("err_cnt", 32'(err_cnt), exp_cnt);
                if (prev_stall) begin
                    check("hold_valid", 32'(out_valid), 32'd1);
                    check("hold_instr", out_instr, prev_instr);
                    check("hold_err", 32'(out_err), 32'(prev_err));
                end
                herr = 1'b0;
                if (out_valid && out_ready) begin
                    if (sb.size() == 0) begin
                        check("unexpected_output", out_instr, 32'hxxxx_xxxx);
                    end else begin
                        e = sb.pop_front();
                        check("out_instr", out_instr, e.instr);
                        check("out_err", 32'(out_err), 32'(e.err));
                        if (e.err == 2'b00) check("round_trip", extend(e.src, out_instr), e.imm);
                        herr = (e.err != 2'b00);
                    end
                end
                if (err_clr)                        exp_cnt = herr ? 1 : 0;
                else if (herr && exp_cnt < CNT_MAX) exp_cnt = exp_cnt + 1;
                prev_stall = out_valid && !out_ready;
                prev_instr = out_instr;
                prev_err   = out_err;
            end
        end
    end

    task automatic send(input logic [2:0] src, input logic [31:0] im, input logic [31:0] bs,
                        input logic use_exp, input logic [31:0] xi, input logic [1:0] xe);
        exp_t e;
        logic acc = 1'b0;
        e.src = src;
        e.imm = im;
        if (use_exp) begin
            e.instr = xi;
            e.err   = xe;
        end else begin
            ref_pack(src, im, bs, e.instr, e.err);
        end
        in_valid = 1'b1;
        immsrc   = src;
        imm      = im;
        base     = bs;
        for (int c = 0; c < 1000 && !acc; c++) begin
            @(negedge clk);
            acc = in_ready;
            if (acc) sb.push_back(e);
            @(posedge clk);
            #1;
        end
        if (!acc) check("accept_timeout", 32'd0, 32'd1);
        in_valid = 1'b0;
    endtask

    task automatic drain();
        for (int c = 0; c < 300 && sb.size() != 0; c++) @(posedge clk);
        check("drain_timeout", 32'(sb.size()), 32'd0);
        @(posedge clk);
        #1;
    endtask

    initial begin
        #500_000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [2:0]  bp_src[4] = '{3'd0, 3'd1, 3'd4, 3'd3};
        logic [31:0] bp_imm[4] = '{32'h0000_0123, 32'hFFFF_F800, 32'hABCD_E000, 32'h000F_FFFE};
        int          bp_idx;
        exp_t        e;

        repeat (3) @(posedge clk);
        @(negedge clk);
        check("rst_out_valid", 32'(out_valid), 32'd0);
        check("rst_out_instr", out_instr, 32'd0);
        check("rst_out_err", 32'(out_err), 32'd0);
        check("rst_err_cnt", 32'(err_cnt), 32'd0);
        @(posedge clk);
        #3 rst_n = 1'b1;
        @(negedge clk);
        check("rst_in_ready", 32'(in_ready), 32'd1);
        @(posedge clk);
        #1 rdy_mode = 1;
        @(posedge clk);
        #1;

        // Directed vectors with latency check on the first.
        send(3'd0, 32'hFFFF_FFFF, 32'h0000_0013, 1'b1, 32'hFFF0_0013, 2'b00);
        @(negedge clk);
        check("latency_n1", 32'(out_valid), 32'd0);
        @(negedge clk);
        check("latency_n2", 32'(out_valid), 32'd1);
        @(posedge clk);
        #1;
        send(3'd2, 32'h0000_0800, 32'h0000_0063, 1'b1, 32'h0000_00E3, 2'b00);
        send(3'd2, 32'h0000_1000, 32'h0000_0063, 1'b1, 32'h8000_0063, 2'b01);
        drain();
        @(negedge clk);
        check("err_cnt_after_b", 32'(err_cnt), 32'd1);
        @(posedge clk);
        #1;
        send(3'd3, 32'h0000_0003, 32'h0000_006F, 1'b1, 32'h0020_006F, 2'b10);
        send(3'd4, 32'h1234_5000, 32'h0000_0037, 1'b1, 32'h1234_5037, 2'b00);
        send(3'd7, 32'h0000_0000, 32'hDEAD_BEEF, 1'b1, 32'hDEAD_BEEF, 2'b11);
        drain();

        // Backpressure: only two of four accepted while the output is blocked.
        rdy_mode = 0;
        bp_idx   = 0;
        for (int c = 0; c < 5; c++) begin
            in_valid = (bp_idx < 4);
            immsrc   = bp_src[bp_idx % 4];
            imm      = bp_imm[bp_idx % 4];
            base     = 32'h5A5A_5A5A + 32'(bp_idx);
            @(negedge clk);
            if (in_ready && bp_idx < 4) begin
                e.src = immsrc;
                e.imm = imm;
                ref_pack(immsrc, imm, base, e.instr, e.err);
                sb.push_back(e);
                bp_idx++;
            end
            @(posedge clk);
            #1;
        end
        check("bp_accepts", 32'(bp_idx), 32'd2);
        @(negedge clk);
        check("bp_in_ready_low", 32'(in_ready), 32'd0);
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        rdy_mode = 1;
        for (int k = 2; k < 4; k++) send(bp_src[k], bp_imm[k], 32'h5A5A_5A5A + 32'(k), 1'b0, '0, '0);
        drain();

        // Randomized traffic with random downstream stalls.
        rdy_mode = 2;
        for (int n = 0; n < 300; n++) begin
            logic [2:0] src;
            src = ($urandom_range(0, 9) == 0) ? 3'($urandom_range(5, 7)) : 3'($urandom_range(0, 4));
            send(src, rand_imm(), $urandom, 1'b0, '0, '0);
            if ($urandom_range(0, 3) == 0) begin
                repeat ($urandom_range(1, 3)) @(posedge clk);
                #1;
            end
        end
        rdy_mode = 1;
        drain();

        // Saturation, then clear colliding with an errored handshake.
        for (int n = 0; n < 260; n++) send(3'd5, $urandom, $urandom, 1'b0, '0, '0);
        drain();
        @(negedge clk);
        check("err_cnt_saturated", 32'(err_cnt), 32'd255);
        @(posedge clk);
        #1;
        send(3'd6, 32'h0, 32'h1111_2222, 1'b0, '0, '0);
        @(posedge clk);
        #1 err_clr = 1'b1;
        @(posedge clk);
        #1 err_clr = 1'b0;
        @(negedge clk);
        check("err_clr_with_hs", 32'(err_cnt), 32'd1);
        @(posedge clk);
        #1;

        // Reset with two entries in flight.
        rdy_mode = 0;
        send(3'd0, 32'h0000_0005, 32'h0000_0013, 1'b0, '0, '0);
        send(3'd2, 32'h0000_1001, 32'h0000_0063, 1'b0, '0, '0);
        #2 rst_n = 1'b0;
        #1;
        check("midrst_out_valid", 32'(out_valid), 32'd0);
        check("midrst_err_cnt", 32'(err_cnt), 32'd0);
        sb.delete();
        @(posedge clk);
        #3 rst_n = 1'b1;
        rdy_mode = 1;
        for (int c = 0; c < 3; c++) begin
            @(negedge clk);
            check("no_stale_output", 32'(out_valid), 32'd0);
        end
        @(posedge clk);
        #1;
        for (int n = 0; n < 10; n++) send(3'($urandom_range(0, 4)), rand_imm(), $urandom, 1'b0, '0, '0);
        drain();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
